branch_selector: RTL and testbench

BRANCH_SELECTOR -- requirements
Module: branch_selector

---
 rtl/branch_selector.sv | 118 +++++++++++
 tb/tb_branch_selector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_selector.sv
`default_nettype none
// ============================================================================
// Module   : branch_selector
// Purpose  : Chooses one redirect per cycle from the ROB and NUM_SRC execution
//            units. The ROB request always wins. Otherwise the oldest eligible
//            execution-unit request wins, judged by 7-bit modulo sqN; ties go
//            to the lowest source index. After an issue, only requests older
//            than the last issued sqN are accepted until the ROB replay ends.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            IN_robBranch      - ROB redirect (76 bits)
//            IN_branches       - NUM_SRC execution-unit redirects, 76 bits each
//            IN_mispredFlush   - ROB replay in progress
//            OUT_branch        - registered winning redirect, bit 0 = valid
//            OUT_busy          - high while ARMED or FLUSHING
// Redirect : [0] valid, [16:1] history, [21:17] fetchID, [22] flush,
//            [36:23] reserved, [43:37] sqN, [75:44] dstPC
// Revision : 1.0 - initial release
// ============================================================================
module branch_selector #(
    parameter int NUM_SRC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [75:0]            IN_robBranch,
    input  logic [NUM_SRC*76-1:0]  IN_branches,
    input  logic                   IN_mispredFlush,
    output logic [75:0]            OUT_branch,
    output logic                   OUT_busy
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ARMED    = 2'd1;
    localparam logic [1:0] c_FLUSHING = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [6:0]  r_last_sqn;
    logic [75:0] r_branch;

    logic [75:0] w_win;
    logic        w_have;
    logic [75:0] w_cand;
    logic        w_elig;

    // a is older than b when the 7-bit wrapped difference is negative.
    function automatic logic f_older(input logic [6:0] a, input logic [6:0] b);
        logic [6:0] d;
        d = a - b;
        return d[6];
    endfunction

    // Winner selection. The strict "older" test against the running best keeps
    // the lowest index on equal sqN because sources are scanned upward.
    always_comb begin
        w_win  = IN_robBranch;
        w_have = IN_robBranch[0];
        w_cand = '0;
        w_elig = 1'b0;
        if (!IN_robBranch[0]) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                w_cand = IN_branches[k*76 +: 76];
                w_elig = w_cand[0] &&
                         ((r_state == c_IDLE) || f_older(w_cand[43:37], r_last_sqn));
                if (w_elig && (!w_have || f_older(w_cand[43:37], w_win[43:37]))) begin
                    w_win  = w_cand;
                    w_have = 1'b1;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an issue always lands in ARMED, even when the replay
    // flag drops in the same cycle.
    always_comb begin
        w_next_state = r_state;
        if (w_have) begin
            w_next_state = c_ARMED;
        end else begin
            case (r_state)
                c_ARMED:    if (IN_mispredFlush)  w_next_state = c_FLUSHING;
                c_FLUSHING: if (!IN_mispredFlush) w_next_state = c_IDLE;
                default:    w_next_state = r_state;
            endcase
        end
    end

    // Output logic (state-derived only)
    always_comb begin
        OUT_busy = (r_state != c_IDLE);
    end

    // Issued redirect and age watermark. With no winner only the valid bit is
    // cleared so the payload bits keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch[0] <= 1'b0;
            r_last_sqn  <= 7'd0;
        end else if (w_have) begin
            r_branch    <= w_win;
            r_last_sqn  <= w_win[43:37];
        end else begin
            r_branch[0] <= 1'b0;
        end
    end

    assign OUT_branch = r_branch;

endmodule
`default_nettype wire

// File: tb/tb_branch_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_selector
// Purpose  : Directed-vector bench for branch_selector with a reference model
//            compared every cycle plus literal checks per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_selector;

    localparam int NUM_SRC = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [75:0]           rob;
    logic [NUM_SRC*76-1:0] br;
    logic                  mflush;
    logic [75:0]           out_branch;
    logic                  out_busy;

    int checks = 0;
    int errors = 0;

    branch_selector #(.NUM_SRC(NUM_SRC)) dut (
        .clk             (clk),
        .rst             (rst),
        .IN_robBranch    (rob),
        .IN_branches     (br),
        .IN_mispredFlush (mflush),
        .OUT_branch      (out_branch),
        .OUT_busy        (out_busy)
    );

    always #5 clk = ~clk;

    // Build a redirect with distinguishable payload fields.
    function automatic logic [75:0] mk(input int sq, input logic [31:0] pc);
        logic [75:0] r;
        r          = '0;
        r[0]       = 1'b1;
        r[16:1]    = 16'hA500 + 16'(sq);
        r[21:17]   = 5'(sq + 3);
        r[22]      = sq[0];
        r[29:23]   = 7'h55;
        r[36:30]   = 7'(sq ^ 7'h2A);
        r[43:37]   = 7'(sq);
        r[75:44]   = pc;
        return r;
    endfunction

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 waiting for replay, 2 replaying
    int          m_mode = 0;
    int          m_last = 0;
    logic        m_valid = 1'b0;
    logic [75:0] m_branch = '0;
    bit          m_ready = 1'b0;

    function automatic bit is_older(input int a, input int b);
        return (((a - b) % 128 + 128) % 128) >= 64;
    endfunction

    always @(posedge clk) begin
        int q[$];
        int best;
        logic [75:0] c;
        m_ready = 1'b1;
        if (rst) begin
            m_valid = 1'b0;
            m_mode  = 0;
            m_last  = 0;
        end else begin
            q.delete();
            for (int k = 0; k < NUM_SRC; k++) begin
                c = br[k*76 +: 76];
                if (c[0] && (m_mode == 0 || is_older(int'(c[43:37]), m_last)))
                    q.push_back(k);
            end
            if (rob[0]) begin
                m_branch = rob;
                m_valid  = 1'b1;
            end else if (q.size() > 0) begin
                best = q[0];
                foreach (q[i]) begin
                    c = br[q[i]*76 +: 76];
                    if (is_older(int'(c[43:37]), int'(br[best*76+37 +: 7])))
                        best = q[i];
                end
                m_branch = br[best*76 +: 76];
                m_valid  = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (m_valid) begin
                m_last = int'(m_branch[43:37]);
                m_mode = 1;
            end else if (m_mode == 1 && mflush) begin
                m_mode = 2;
            end else if (m_mode == 2 && !mflush) begin
                m_mode = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ready) begin
            checks++;
            if (out_branch[0] !== m_valid || out_busy !== (m_mode != 0) ||
                (m_valid && out_branch !== m_branch)) begin
                errors++;
                $display("FAIL model t=%0t: got valid=%b busy=%b br=%h, expected valid=%b busy=%b br=%h",
                         $time, out_branch[0], out_busy, out_branch,
                         m_valid, (m_mode != 0), m_branch);
            end
        end
    end

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr();
        rob = '0;
        br  = '0;
    endtask

    initial begin
        rst = 1'b1; mflush = 1'b0; clr();
        tick(); tick();
        chk("reset_valid", 76'(out_branch[0]), 76'd0);
        chk("reset_busy",  76'(out_busy),      76'd0);
        rst = 1'b0;
        tick();

        // Oldest of two EU requests wins.
        br[1*76 +: 76] = mk(10, 32'h0000_1000);
        br[3*76 +: 76] = mk(5,  32'h0000_3000);
        tick(); clr();
        chk("r025_valid", 76'(out_branch[0]),     76'd1);
        chk("r025_sqn",   76'(out_branch[43:37]), 76'd5);
        chk("r025_pc",    76'(out_branch[75:44]), 76'h3000);
        chk("r025_busy",  76'(out_busy),          76'd1);
        tick();
        chk("r025_once",  76'(out_branch[0]),     76'd0);
        mflush = 1'b1; tick();
        mflush = 1'b0; tick();
        chk("idle_again", 76'(out_busy), 76'd0);

        // Watermark filtering after an issue with sqN 20.
        br[0 +: 76] = mk(20, 32'h2020); tick(); clr();
        br[0 +: 76] = mk(25, 32'h2525); tick(); clr();
        chk("r026_drop", 76'(out_branch[0]), 76'd0);
        br[2*76 +: 76] = mk(15, 32'h1515); tick(); clr();
        chk("r026_issue", 76'(out_branch[43:37]), 76'd15);
        br[0 +: 76] = mk(15, 32'h1616); tick(); clr();
        chk("equal_drop", 76'(out_branch[0]), 76'd0);

        // Reset with a live request: discarded.
        rst = 1'b1; br[0 +: 76] = mk(3, 32'h0303); tick();
        rst = 1'b0; clr(); tick();
        chk("rst_no_issue", 76'(out_branch[0]), 76'd0);
        chk("rst_idle",     76'(out_busy),      76'd0);

        // Wrap-around: 126 is older than 2.
        br[0 +: 76]  = mk(126, 32'hAAAA_0126);
        br[1*76 +: 76] = mk(2, 32'hBBBB_0002);
        tick(); clr();
        chk("r027_sqn", 76'(out_branch[43:37]), 76'd126);
        br[0 +: 76] = mk(3, 32'h0003); tick(); clr();
        chk("r027_drop", 76'(out_branch[0]), 76'd0);
        br[1*76 +: 76] = mk(125, 32'h0125); tick(); clr();
        chk("wrap_older", 76'(out_branch[43:37]), 76'd125);

        // ROB priority over an older EU request.
        rob = mk(40, 32'hC0DE_0040);
        br[0 +: 76] = mk(30, 32'h0030);
        tick(); clr();
        chk("r028_sqn", 76'(out_branch[43:37]), 76'd40);
        chk("r028_pc",  76'(out_branch[75:44]), 76'hC0DE_0040);

        // Replay sequence, then a younger request issues from IDLE.
        mflush = 1'b1; tick(); tick(); tick();
        chk("r029_flushing", 76'(out_busy), 76'd1);
        mflush = 1'b0; tick();
        chk("r029_idle", 76'(out_busy), 76'd0);
        br[2*76 +: 76] = mk(90, 32'h9090); tick(); clr();
        chk("r029_issue", 76'(out_branch[43:37]), 76'd90);

        // Issue coincident with replay end stays ARMED.
        mflush = 1'b1; tick();
        mflush = 1'b0; br[3*76 +: 76] = mk(80, 32'h8080); tick(); clr();
        chk("r020_issue", 76'(out_branch[43:37]), 76'd80);
        tick();
        chk("r020_armed", 76'(out_busy), 76'd1);

        // Reset during replay with a request pending.
        mflush = 1'b1; tick();
        rst = 1'b1; br[0 +: 76] = mk(10, 32'h1010); tick();
        rst = 1'b0; mflush = 1'b0; clr(); tick();
        chk("r030_valid", 76'(out_branch[0]), 76'd0);
        chk("r030_busy",  76'(out_busy),      76'd0);

        // Tie on sqN: lowest index wins.
        br[1*76 +: 76] = mk(60, 32'h1111);
        br[2*76 +: 76] = mk(60, 32'h2222);
        tick(); clr();
        chk("tie_pc", 76'(out_branch[75:44]), 76'h1111);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
